alu_exec_ctrl: RTL and testbench

Multi-cycle execute controller that drives the 8-bit combinational ALU in the mini-CPU datapath. It accepts one instruction per valid/ready handshake and reads two operands from an internal 4x8 register file. It presents the operands and opcode to the ALU, then captures the ALU result and the cf/ovf/z/neg flags. It writes the result back, pulses `done`, and holds the flags in an architectural flag register for later branch logic.

---
 rtl/alu_exec_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute controller for the mini-CPU: accepts LDI/ALU instructions, sequences the
// external combinational ALU through IDLE -> OPER -> WB and writes results back.
module alu_exec_ctrl #(
  parameter int NREGS = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_cf,
  input  logic        alu_ovf,
  input  logic        alu_z,
  input  logic        alu_neg,
  output logic [3:0]  flags,
  output logic        done,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  regs_q [NREGS];
  logic [7:0]  regs_d [NREGS];
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic [7:0]  res_q, res_d;
  logic [1:0]  rd_q, rd_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  flags_q, flags_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rd_d    = rd_q;
    op_d    = op_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (instr[15]) begin
            // LDI skips the ALU entirely and leaves the flag register alone
            rd_d    = instr[9:8];
            res_d   = instr[7:0];
            state_d = WB;
            done_d  = 1'b1;
          end else begin
            op_d    = instr[14:12];
            rd_d    = instr[11:10];
            opa_d   = regs_q[instr[9:8]];
            opb_d   = regs_q[instr[7:6]];
            state_d = OPER;
          end
        end
      end
      OPER: begin
        res_d   = alu_result;
        flags_d = {alu_cf, alu_ovf, alu_z, alu_neg};
        state_d = WB;
        done_d  = 1'b1;
      end
      WB: begin
        regs_d[rd_q] = res_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Ready is gated by reset directly so nothing is accepted while it is held.
  assign instr_ready = (state_q == IDLE) && !areset;
  assign alu_a       = (state_q == OPER) ? opa_q : 8'd0;
  assign alu_b       = (state_q == OPER) ? opb_q : 8'd0;
  assign alu_op      = (state_q == OPER) ? op_q  : 3'd0;
  assign flags       = flags_q;
  assign done        = done_q;
  assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural ALU drives the DUT, and a
// register/flag model built from the instruction semantics predicts results.
`timescale 1ns/100ps
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        areset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cf, alu_ovf, alu_z, alu_neg;
  logic [3:0]  flags;
  logic        done;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int assertions = 0;
  int failures   = 0;

  logic [7:0] mregs [4];
  logic [3:0] mflags;

  always #10 clk = ~clk;

  alu_exec_ctrl #(.NREGS(4)) dut (
    .clk(clk), .areset(areset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_ovf(alu_ovf),
    .alu_z(alu_z), .alu_neg(alu_neg),
    .flags(flags), .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Reference ALU: returns {cf, ovf, z, neg, result}
  function automatic logic [11:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 8'd0;
    case (op)
      3'd0, 3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1, 3'd3: begin
        r = a - b; c = (a >= b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: begin r = {a[6:0], 1'b0}; c = a[7]; end
    endcase
    return {c, v, (r == 8'd0), r[7], r};
  endfunction

  assign {alu_cf, alu_ovf, alu_z, alu_neg, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [15:0] ldi(logic [1:0] rd, logic [7:0] imm);
    return {1'b1, 5'd0, rd, imm};
  endfunction

  function automatic logic [15:0] aluins(logic [2:0] op, logic [1:0] rd, logic [1:0] ra, logic [1:0] rb);
    return {1'b0, op, rd, ra, rb, 6'd0};
  endfunction

  task automatic model_apply(input logic [15:0] ins);
    logic [11:0] o;
    if (ins[15]) begin
      mregs[ins[9:8]] = ins[7:0];
    end else begin
      o = alu_fn(ins[14:12], mregs[ins[9:8]], mregs[ins[7:6]]);
      mregs[ins[11:10]] = o[7:0];
      mflags = o[11:8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mflags = 4'd0;
  endtask

  // Runs one instruction; returns done latency (negedges after accept), the ALU
  // inputs seen in the first cycle after accept, and whether ALU inputs were 0 in WB.
  task automatic exec(input logic [15:0] ins, output int lat,
                      output logic [7:0] oa, output logic [7:0] ob,
                      output logic [2:0] oop, output logic wb_zero);
    int w;
    w = 0; lat = 0; oa = 8'd0; ob = 8'd0; oop = 3'd0; wb_zero = 1'b0;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    assertions++;
    if (w >= 20) begin
      failures++;
      $display("FAIL exec_ready_timeout got ready=%0b required 1", instr_ready);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'($urandom);
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        oa = alu_a; ob = alu_b; oop = alu_op;
      end
      if (done) break;
    end
    wb_zero = (alu_a == 8'd0) && (alu_b == 8'd0) && (alu_op == 3'd0);
    model_apply(ins);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    logic [7:0] oa, ob;
    logic [2:0] oop;
    logic wz;
    exec(ldi(2'd1, 8'd200), lat, oa, ob, oop, wz);
    exec(ldi(2'd2, 8'd100), lat, oa, ob, oop, wz);
    exec(aluins(3'd0, 2'd3, 2'd1, 2'd2), lat, oa, ob, oop, wz);
    @(negedge clk);
    instr = aluins(3'd0, 2'd0, 2'd1, 2'd2); instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    #1;
    assertions++;
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got %0b required 0", done); end
    assertions++;
    if (flags !== 4'b0000) begin failures++; $display("FAIL rst_flags got %b required 0000", flags); end
    assertions++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_during got %0b required 0", instr_ready); end
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      assertions++;
      if (dbg_data !== 8'd0) begin failures++; $display("FAIL rst_reg%0d got %0d required 0", r, dbg_data); end
    end
    @(negedge clk);
    assertions++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_held got %0b required 0", instr_ready); end
    @(negedge clk);
    areset = 1'b0;
    model_reset();
    #1;
    assertions++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got %0b required 1", instr_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      assertions++;
      if (done !== 1'b0) begin failures++; $display("FAIL rst_no_wb cycle %0d got done=%0b required 0", c, done); end
    end
    dbg_sel = 2'd0;
    #1;
    assertions++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL rst_discard_r0 got %0d required 0", dbg_data); end
    $display("test_reset complete");
  endtask

  task automatic test_addu();
    int lat;
    logic [7:0] oa, ob;
    logic [2:0] oop;
    logic wz;
    exec(ldi(2'd1, 8'd200), lat, oa, ob, oop, wz);
    assertions++;
    if (lat != 1) begin failures++; $display("FAIL ldi_latency got %0d required 1", lat); end
    exec(ldi(2'd2, 8'd100), lat, oa, ob, oop, wz);
    exec(aluins(3'd0, 2'd3, 2'd1, 2'd2), lat, oa, ob, oop, wz);
    assertions++;
    if (lat != 2) begin failures++; $display("FAIL addu_latency got %0d required 2", lat); end
    assertions++;
    if (oa !== 8'd200 || ob !== 8'd100 || oop !== 3'd0) begin
      failures++; $display("FAIL addu_alu_in got a=%0d b=%0d op=%0d required 200 100 0", oa, ob, oop);
    end
    dbg_sel = 2'd3;
    #1;
    assertions++;
    if (dbg_data !== 8'd44) begin failures++; $display("FAIL addu_r3 got %0d required 44", dbg_data); end
    assertions++;
    if (flags !== 4'b1000) begin failures++; $display("FAIL addu_flags got %b required 1000", flags); end
    $display("test_addu complete");
  endtask

  task automatic test_subu();
    int lat;
    logic [7:0] oa, ob;
    logic [2:0] oop;
    logic wz;
    exec(ldi(2'd0, 8'd5), lat, oa, ob, oop, wz);
    exec(ldi(2'd1, 8'd7), lat, oa, ob, oop, wz);
    exec(aluins(3'd1, 2'd2, 2'd0, 2'd1), lat, oa, ob, oop, wz);
    dbg_sel = 2'd2;
    #1;
    assertions++;
    if (dbg_data !== 8'd254) begin failures++; $display("FAIL subu_neg_r2 got %0d required 254", dbg_data); end
    assertions++;
    if (flags !== 4'b0001) begin failures++; $display("FAIL subu_neg_flags got %b required 0001", flags); end
    exec(aluins(3'd1, 2'd2, 2'd1, 2'd0), lat, oa, ob, oop, wz);
    #1;
    assertions++;
    if (dbg_data !== 8'd2) begin failures++; $display("FAIL subu_pos_r2 got %0d required 2", dbg_data); end
    assertions++;
    if (flags !== 4'b1000) begin failures++; $display("FAIL subu_pos_flags got %b required 1000", flags); end
    $display("test_subu complete");
  endtask

  task automatic test_adds_sll();
    int lat;
    logic [7:0] oa, ob;
    logic [2:0] oop;
    logic wz;
    exec(ldi(2'd0, 8'd100), lat, oa, ob, oop, wz);
    exec(aluins(3'd2, 2'd1, 2'd0, 2'd0), lat, oa, ob, oop, wz);
    dbg_sel = 2'd1;
    #1;
    assertions++;
    if (dbg_data !== 8'hC8) begin failures++; $display("FAIL adds_r1 got %h required c8", dbg_data); end
    assertions++;
    if (flags !== 4'b0101) begin failures++; $display("FAIL adds_flags got %b required 0101", flags); end
    exec(ldi(2'd2, 8'h80), lat, oa, ob, oop, wz);
    assertions++;
    if (flags !== 4'b0101) begin failures++; $display("FAIL ldi_keeps_flags got %b required 0101", flags); end
    exec(aluins(3'd7, 2'd2, 2'd2, 2'd2), lat, oa, ob, oop, wz);
    dbg_sel = 2'd2;
    #1;
    assertions++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL sll_r2 got %0d required 0", dbg_data); end
    assertions++;
    if (flags !== 4'b1010) begin failures++; $display("FAIL sll_flags got %b required 1010", flags); end
    $display("test_adds_sll complete");
  endtask

  task automatic test_alias();
    int lat;
    logic [7:0] oa, ob;
    logic [2:0] oop;
    logic wz;
    exec(ldi(2'd3, 8'd3), lat, oa, ob, oop, wz);
    exec(aluins(3'd4, 2'd3, 2'd3, 2'd3), lat, oa, ob, oop, wz);
    dbg_sel = 2'd3;
    #1;
    assertions++;
    if (dbg_data !== 8'd3) begin failures++; $display("FAIL alias_and_r3 got %0d required 3", dbg_data); end
    exec(aluins(3'd6, 2'd3, 2'd3, 2'd3), lat, oa, ob, oop, wz);
    #1;
    assertions++;
    if (dbg_data !== 8'd0) begin failures++; $display("FAIL alias_xor_r3 got %0d required 0", dbg_data); end
    assertions++;
    if (flags !== 4'b0010) begin failures++; $display("FAIL alias_xor_flags got %b required 0010", flags); end
    $display("test_alias complete");
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [3];
    int acc [3];
    int k, dones;
    for (int i = 0; i < 3; i++) begin
      q[i] = aluins(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom));
    end
    k = 0; dones = 0;
    for (int i = 0; i < 3; i++) acc[i] = -1;
    @(negedge clk);
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (done) dones++;
      if (instr_ready && k < 3) begin
        acc[k] = cyc; instr = q[k]; k++;
      end else if (instr_ready) begin
        instr_valid = 1'b0;
      end else begin
        instr = 16'($urandom);
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_apply(q[i]);
    assertions++;
    if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      failures++; $display("FAIL b2b_spacing got %0d,%0d,%0d required 3 apart", acc[0], acc[1], acc[2]);
    end
    assertions++;
    if (dones != 3) begin failures++; $display("FAIL b2b_done_count got %0d required 3", dones); end
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      assertions++;
      if (dbg_data !== mregs[r]) begin failures++; $display("FAIL b2b_reg%0d got %0d required %0d", r, dbg_data, mregs[r]); end
    end
    assertions++;
    if (flags !== mflags) begin failures++; $display("FAIL b2b_flags got %b required %b", flags, mflags); end
    $display("test_back_to_back complete: accepts at %0d %0d %0d, %0d done pulses", acc[0], acc[1], acc[2], dones);
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] oa, ob, ea, eb;
    logic [2:0] oop;
    logic wz;
    logic [15:0] ins;
    for (int n = 0; n < 40; n++) begin
      ins = 16'($urandom);
      ea = mregs[ins[9:8]];
      eb = mregs[ins[7:6]];
      exec(ins, lat, oa, ob, oop, wz);
      assertions++;
      if (lat != (ins[15] ? 1 : 2)) begin failures++; $display("FAIL rnd%0d_latency got %0d required %0d", n, lat, ins[15] ? 1 : 2); end
      if (!ins[15]) begin
        assertions++;
        if (oa !== ea || ob !== eb || oop !== ins[14:12]) begin
          failures++; $display("FAIL rnd%0d_alu_in got %0d %0d %0d required %0d %0d %0d", n, oa, ob, oop, ea, eb, ins[14:12]);
        end
      end
      assertions++;
      if (!wz) begin failures++; $display("FAIL rnd%0d_alu_idle got nonzero ALU inputs in WB required 0", n); end
      assertions++;
      if (flags !== mflags) begin failures++; $display("FAIL rnd%0d_flags got %b required %b", n, flags, mflags); end
      for (int r = 0; r < 4; r++) begin
        dbg_sel = 2'(r);
        #1;
        assertions++;
        if (dbg_data !== mregs[r]) begin failures++; $display("FAIL rnd%0d_reg%0d got %0d required %0d", n, r, dbg_data, mregs[r]); end
      end
      $display("rnd %0d instr=%h lat=%0d flags=%b", n, ins, lat, flags);
    end
  endtask

  initial begin
    areset = 1'b1; instr_valid = 1'b0; instr = 16'd0; dbg_sel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    areset = 1'b0;
    test_reset();
    test_addu();
    test_subu();
    test_adds_sll();
    test_alias();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
